restoring_divider: RTL
======================

// Module: restoring_divider
// PURPOSE
//  Sequential unsigned restoring divider: Q = dividend / divisor, R = dividend % divisor.
//  Inverse of the Booth multiplier; pairs with it in the arithmetic unit, same control-unit/datapath split.
//  Resolves one quotient bit per 2-cycle SHIFT/TEST iteration (N iterations).
//  Start/busy/done handshake toward the host controller.
// PARAMETERS
//  N   8   operand width (dividend, divisor, quotient, remainder); N >= 2
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   request; sampled only in IDLE
//  dividend     in   N   captured on the accepted start edge
//  divisor      in   N   captured on the accepted start edge
//  busy         out  1   high in every state except IDLE
//  done         out  1   1-cycle pulse, result valid
//  quotient     out  N   held from DONE until next accepted start
//  remainder    out  N   held from DONE until next accepted start
//  div_by_zero  out  1   valid with done; held like quotient
// BEHAVIOUR
//  Reset (rst_n=0, any time incl. mid-operation): state=IDLE; busy, done, div_by_zero = 0;
//   quotient, remainder, A, Q, M, count = 0. Leaving reset: first edge evaluates IDLE.
//  States (registered, Moore outputs):
//   IDLE : start=1 -> capture Q<=dividend, M<=divisor; go INIT. Else stay.
//   INIT : A<=0 (N+1 bits), count<=0. M==0 -> DONE with div_by_zero path. Else -> SHIFT.
//   SHIFT: {A,Q} <= {A,Q} << 1 (A[N:0] takes old A[N-1:0],Q[N-1]; Q[0]<=0) -> TEST.
//   TEST : D = A - {1'b0,M} (N+1 bits). D[N]=1 -> A unchanged (restore), Q[0]<=0;
//          else A<=D, Q[0]<=1. count<=count+1. count==N-1 -> DONE, else -> SHIFT.
//   DONE : done=1 for exactly this cycle; quotient<=Q, remainder<=A[N-1:0],
//          div_by_zero set/cleared here; -> IDLE unconditionally.
//  Divide by zero: quotient={N{1'b1}}, remainder=dividend, div_by_zero=1.
//  Latency: start sampled at edge e0; done high after edge e(2N+1), i.e. cycle 2N+2
//   after the start cycle (N=8: 18). Divide-by-zero: done after e1 (2 cycles).
//  start while busy (INIT..DONE): ignored, no re-capture. start in the DONE cycle: ignored;
//   back-to-back needs start held/reasserted in IDLE. Operand changes after capture: no effect.
//  count width clog2(N); never wraps (exit at N-1). A needs N+1 bits; the sign bit
//   comes only from the subtractor, never from the shift.
//  Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package divider_pkg: state enum (IDLE, INIT, SHIFT, TEST, DONE, 3-bit encoding),
//   DIV_W default constant.
//  restoring_divider = control FSM + counter; one sub-module restoring_divider_dp (A, Q, M
//   registers, subtractor, shift/restore muxes) driven by control strobes
//   load, clear_a, shift, test, latch_out. Same split as the Booth multiplier.
// TESTING (N=8 unless noted)
//  1. 100/7 -> at cycle 18: done=1, quotient=14, remainder=2, div_by_zero=0; busy drops next cycle.
//  2. 255/1 and 0/5 -> quotient=255 rem=0; quotient=0 rem=0; 7/9 -> quotient=0, rem=7.
//  3. 13/0 -> done at cycle 2, div_by_zero=1, quotient=255, remainder=13.
//  4. start re-pulsed with 50/3 during 100/7 run -> result 14/2, no extra done pulse.
//  5. rst_n low at cycle 9 of 200/9 -> all outputs 0 immediately; new 200/9 -> 22 rem 2.
//  6. Random 10k pairs, N=8 and N=16, vs reference model; done exactly one pulse per start.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: the control-state
// encoding and the default operand width.
package divider_pkg;

   // Default operand width for dividend, divisor, quotient and remainder.
   localparam int DIV_W = 8;

   // Control states. The encoding is fixed at 3 bits so that state values are
   // stable when probed in a waveform or compared across builds.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      SHIFT = 3'd2,
      TEST  = 3'd3,
      DONE  = 3'd4
   } div_state_t;

endpackage : divider_pkg

// File: rtl/restoring_divider_dp.sv
// Datapath of the restoring divider: partial remainder A (N+1 bits),
// dividend/quotient shift register Q, divisor M, the A-M subtractor and the
// result registers. Everything here is steered by strobes from the control FSM.
module restoring_divider_dp
   import divider_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear_a,
   input  logic         shift,
   input  logic         test,
   input  logic         latch_out,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         m_zero,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   logic [N:0]   a_reg;
   logic [N:0]   a_next;
   logic [N-1:0] q_reg;
   logic [N-1:0] q_next;
   logic [N-1:0] m_reg;
   logic [N-1:0] m_next;
   logic [N:0]   diff;
   logic [N-1:0] q_shl;
   logic [N-1:0] quotient_reg;
   logic [N-1:0] remainder_reg;
   logic         dbz_reg;

   // Trial subtraction. Bit N acts as the borrow: set means A < M, so restore.
   assign diff   = a_reg - {1'b0, m_reg};
   assign m_zero = (m_reg == '0);

   // Q shifted left by one with a zero entering the quotient LSB.
   assign q_shl[0] = 1'b0;
   for (genvar gi = 1; gi < N; gi++) begin : g_qshift
      assign q_shl[gi] = q_reg[gi-1];
   end

   // Next-state selection for A, Q and M from the control strobes.
   always_comb begin
      a_next = a_reg;
      q_next = q_reg;
      m_next = m_reg;
      if (load) begin
         q_next = dividend;
         m_next = divisor;
      end
      if (clear_a) begin
         a_next = '0;
      end
      if (shift) begin
         // The top bit of A is a magnitude bit here, not a sign; a negative
         // value can only appear transiently in diff.
         a_next = {a_reg[N-1:0], q_reg[N-1]};
         q_next = q_shl;
      end
      if (test) begin
         if (!diff[N]) begin
            a_next = diff;
         end
         q_next[0] = ~diff[N];
      end
   end

   // Working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         q_reg <= '0;
         m_reg <= '0;
      end else begin
         a_reg <= a_next;
         q_reg <= q_next;
         m_reg <= m_next;
      end
   end

   // Result registers. They are loaded from the next-state values so the
   // result is already visible in the cycle where done is high. The zero-divisor
   // path is taken from INIT, where Q still holds the untouched dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else if (latch_out) begin
         if (clear_a) begin
            quotient_reg  <= '1;
            remainder_reg <= q_reg;
            dbz_reg       <= 1'b1;
         end else begin
            quotient_reg  <= q_next;
            remainder_reg <= a_next[N-1:0];
            dbz_reg       <= 1'b0;
         end
      end
   end

   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dbz_reg;

endmodule : restoring_divider_dp

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider (top): control FSM plus iteration
// counter, driving the restoring_divider_dp datapath. One quotient bit is
// resolved per SHIFT/TEST pair; start/busy/done handshake toward the host.
module restoring_divider
   import divider_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   div_state_t    state_reg;
   logic [CW-1:0] count_reg;
   logic          busy_reg;
   logic          done_reg;

   logic          load;
   logic          clear_a;
   logic          shift;
   logic          test;
   logic          latch_out;
   logic          m_zero;

   // Datapath strobes decoded from the current state.
   always_comb begin
      load      = (state_reg == IDLE) && start;
      clear_a   = (state_reg == INIT);
      shift     = (state_reg == SHIFT);
      test      = (state_reg == TEST);
      latch_out = ((state_reg == INIT) && m_zero) ||
                  ((state_reg == TEST) && (count_reg == LAST));
   end

   // Control FSM with registered busy/done and the iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg <= INIT;
                  busy_reg  <= 1'b1;
               end
            end
            INIT: begin
               count_reg <= '0;
               if (m_zero) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg <= SHIFT;
               end
            end
            SHIFT: begin
               state_reg <= TEST;
            end
            TEST: begin
               count_reg <= count_reg + 1'b1;
               if (count_reg == LAST) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg <= SHIFT;
               end
            end
            DONE: begin
               // start is deliberately not looked at here.
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   restoring_divider_dp #(
      .N (N)
   ) u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .clear_a     (clear_a),
      .shift       (shift),
      .test        (test),
      .latch_out   (latch_out),
      .dividend    (dividend),
      .divisor     (divisor),
      .m_zero      (m_zero),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   assign busy = busy_reg;
   assign done = done_reg;

endmodule : restoring_divider
